alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: grants one operation at a time,
// holds it on the ALU for one EXEC cycle and returns the captured result.
// Optional ALU_ARB_ROUND_ROBIN_EN: round-robin grant on contention (default: req0 wins).
module alu_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_aluop,
   input  logic [5:0]  req0_funct,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_aluop,
   input  logic [5:0]  req1_funct,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic [2:0]  alu_op,
   output logic [5:0]  alu_funct,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [3:0]  alu_operation,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned OP_W     = 3;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ALUCTL_W = 4;
   localparam logic [ALUCTL_W-1:0] ALU_CTL_DEFAULT = ALUCTL_W'(4'b1001);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_e;

   typedef struct packed {
      logic [OP_W-1:0]    op;
      logic [FUNCT_W-1:0] funct;
      logic [DATA_W-1:0]  a;
      logic [DATA_W-1:0]  b;
   } alu_req_t;

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   alu_req_t          alu_req_q, alu_req_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp0_valid_q, rsp0_valid_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic              busy_q, busy_d;

   logic     grant_c;
   logic     idle_c;
   logic     xfer_c;
   alu_req_t req0_c, req1_c;

   assign req0_c = '{op: req0_aluop, funct: req0_funct, a: req0_a, b: req0_b};
   assign req1_c = '{op: req1_aluop, funct: req1_funct, a: req1_a, b: req1_b};

   // Grant select: 0 = req0, 1 = req1; only meaningful when some requester is valid.
   always_comb begin
      grant_c = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (req0_valid && req1_valid) begin
         grant_c = ~last_grant_q;
      end else begin
         grant_c = req1_valid;
      end
`else
      grant_c = ~req0_valid & req1_valid;
`endif
   end

   // Readies are held low while reset is asserted, even mid-operation.
   assign idle_c     = (state_q == S_IDLE) && reset;
   assign req0_ready = idle_c && req0_valid && !grant_c;
   assign req1_ready = idle_c && req1_valid && grant_c;
   assign xfer_c     = req0_ready || req1_ready;

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      alu_req_d    = alu_req_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (xfer_c) begin
               alu_req_d    = grant_c ? req1_c : req0_c;
               last_grant_d = grant_c;
               state_d      = S_EXEC;
            end
         end
         S_EXEC: begin
            // last_grant_q names the owner of the operation now on the ALU.
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_err_d    = (alu_operation == ALU_CTL_DEFAULT);
            rsp0_valid_d = ~last_grant_q;
            rsp1_valid_d = last_grant_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_EXEC);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         alu_req_q    <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         alu_req_q    <= alu_req_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign alu_op     = alu_req_q.op;
   assign alu_funct  = alu_req_q.funct;
   assign alu_a      = alu_req_q.a;
   assign alu_b      = alu_req_q.b;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; honours ALU_ARB_ROUND_ROBIN_EN like the RTL.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_aluop, req1_aluop;
   logic [5:0]  req0_funct, req1_funct;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  alu_op;
   logic [5:0]  alu_funct;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_operation;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_err;
   logic        busy;
   logic        force_err;

   alu_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
      .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
      .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
      .alu_operation(alu_operation), .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
   );

   // Shared ALU control unit and ALU, combinational from the arbiter's alu_* outputs.
   function automatic logic [3:0] ctl_decode(input logic [2:0] op, input logic [5:0] f);
      if (op != 3'b111) return 4'b1001;
      case (f)
         6'h20:   return 4'b0011;
         6'h22:   return 4'b0100;
         6'h24:   return 4'b0000;
         6'h25:   return 4'b0001;
         default: return 4'b1001;
      endcase
   endfunction

   function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'b0011: return a + b;
         4'b0100: return a - b;
         4'b0000: return a & b;
         4'b0001: return a | b;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_operation = force_err ? 4'b1001 : ctl_decode(alu_op, alu_funct);
   assign alu_result    = alu_fn(alu_operation, alu_a, alu_b);
   assign alu_zero      = (alu_result == 32'd0);

   // Reference model: whole transactions, owner, predicted response.
   bit          m_exec, m_last, m_v0, m_v1, m_zero, m_err;
   logic [2:0]  m_op;
   logic [5:0]  m_funct;
   logic [31:0] m_a, m_b, m_res;
   int          n_checks = 0;
   int          n_pass = 0;
   int          obs[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic bit pick_winner(input bit v0, input bit v1, input bit last);
      if (v0 && v1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         return !last;
`else
         return 1'b0;
`endif
      end
      return !v0;
   endfunction

   // Intended arithmetic of a MIPS R-type op; unknown functs or a forced code are errors.
   task automatic ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit fe, output logic [31:0] r, output bit err);
      err = fe;
      r   = 32'd0;
      if (!fe) begin
         case (f)
            6'h20:   r = a + b;
            6'h22:   r = a - b;
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            default: err = 1'b1;
         endcase
      end
   endtask

   task automatic at_negedge();
      bit w, rdy;
      @(negedge clk);
      w   = pick_winner(req0_valid, req1_valid, m_last);
      rdy = !m_exec && reset;
      check_eq("req0_ready", 32'(req0_ready), 32'(rdy && req0_valid && !w));
      check_eq("req1_ready", 32'(req1_ready), 32'(rdy && req1_valid && w));
      check_eq("busy", 32'(busy), 32'(m_exec));
      check_eq("rsp0_valid", 32'(rsp0_valid), 32'(m_v0));
      check_eq("rsp1_valid", 32'(rsp1_valid), 32'(m_v1));
      check_eq("rsp_result", rsp_result, m_res);
      check_eq("rsp_zero", 32'(rsp_zero), 32'(m_zero));
      check_eq("rsp_err", 32'(rsp_err), 32'(m_err));
      check_eq("alu_op", 32'(alu_op), 32'(m_op));
      check_eq("alu_funct", 32'(alu_funct), 32'(m_funct));
      check_eq("alu_a", alu_a, m_a);
      check_eq("alu_b", alu_b, m_b);
      if (rsp0_valid) obs.push_back(0);
      if (rsp1_valid) obs.push_back(1);
   endtask

   task automatic at_posedge();
      bit w;
      logic [31:0] r;
      bit e;
      @(posedge clk);
      if (!reset) begin
         m_exec = 0; m_last = 1; m_v0 = 0; m_v1 = 0;
         m_res = 0; m_zero = 0; m_err = 0;
         m_op = 0; m_funct = 0; m_a = 0; m_b = 0;
      end else begin
         m_v0 = 0;
         m_v1 = 0;
         if (m_exec) begin
            ref_alu(m_funct, m_a, m_b, force_err, r, e);
            m_res  = r;
            m_err  = e;
            m_zero = (r == 32'd0);
            m_v0   = !m_last;
            m_v1   = m_last;
            m_exec = 0;
         end else if (req0_valid || req1_valid) begin
            w       = pick_winner(req0_valid, req1_valid, m_last);
            m_op    = w ? req1_aluop : req0_aluop;
            m_funct = w ? req1_funct : req0_funct;
            m_a     = w ? req1_a : req0_a;
            m_b     = w ? req1_b : req0_b;
            m_last  = w;
            m_exec  = 1;
         end
      end
      #1;
   endtask

   task automatic cycle();
      at_negedge();
      at_posedge();
   endtask

   task automatic drive0(input bit v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      req0_valid = v; req0_aluop = 3'b111; req0_funct = f; req0_a = a; req0_b = b;
   endtask

   task automatic drive1(input bit v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      req1_valid = v; req1_aluop = 3'b111; req1_funct = f; req1_a = a; req1_b = b;
   endtask

   initial begin
      int exp_g[4];
      logic [5:0] functs[5];
      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h3F};
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      reset = 1'b0;
      force_err = 1'b0;
      drive0(0, 6'h20, 0, 0);
      drive1(0, 6'h20, 0, 0);
      at_posedge();
      repeat (2) cycle();
      reset = 1'b1;
      cycle();

      // Single add from req0: 5 + 7.
      drive0(1, 6'h20, 5, 7);
      cycle();
      drive0(0, 6'h20, 5, 7);
      cycle();
      at_negedge();
      check_eq("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check_eq("add_result", rsp_result, 32'd12);
      check_eq("add_zero", 32'(rsp_zero), 32'd0);
      check_eq("add_err", 32'(rsp_err), 32'd0);
      at_posedge();

      // req1 subtract 9 - 9 sets the zero flag.
      drive1(1, 6'h22, 9, 9);
      cycle();
      drive1(0, 6'h22, 9, 9);
      cycle();
      at_negedge();
      check_eq("sub_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check_eq("sub_result", rsp_result, 32'd0);
      check_eq("sub_zero", 32'(rsp_zero), 32'd1);
      at_posedge();

      // Continuous contention for four operations.
      obs.delete();
      drive0(1, 6'h20, 1, 2);
      drive1(1, 6'h22, 10, 3);
      repeat (7) cycle();
      drive0(0, 6'h20, 1, 2);
      drive1(0, 6'h22, 10, 3);
      repeat (2) cycle();
      check_eq("contend_count", 32'(obs.size()), 32'd4);
      for (int i = 0; i < 4 && i < obs.size(); i++)
         check_eq($sformatf("contend_grant%0d", i), 32'(obs[i]), 32'(exp_g[i]));

      // Forced default control code, then a legal op clears rsp_err.
      force_err = 1'b1;
      drive0(1, 6'h20, 3, 4);
      cycle();
      drive0(0, 6'h20, 3, 4);
      cycle();
      at_negedge();
      check_eq("err_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check_eq("err_flag", 32'(rsp_err), 32'd1);
      at_posedge();
      force_err = 1'b0;
      drive0(1, 6'h20, 3, 4);
      cycle();
      drive0(0, 6'h20, 3, 4);
      cycle();
      at_negedge();
      check_eq("legal_err_clear", 32'(rsp_err), 32'd0);
      check_eq("legal_result", rsp_result, 32'd7);
      at_posedge();

      // Reset during EXEC aborts the operation.
      drive0(1, 6'h20, 100, 200);
      drive1(1, 6'h25, 6, 9);
      cycle();
      reset = 1'b0;
      drive0(0, 6'h20, 100, 200);
      drive1(0, 6'h25, 6, 9);
      cycle();
      reset = 1'b1;
      at_negedge();
      check_eq("abort_rsp0", 32'(rsp0_valid), 32'd0);
      check_eq("abort_rsp1", 32'(rsp1_valid), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_alu_a", alu_a, 32'd0);
      check_eq("abort_result", rsp_result, 32'd0);
      at_posedge();
      drive0(1, 6'h24, 32'hF0F0, 32'hFF00);
      drive1(1, 6'h25, 6, 9);
      at_negedge();
      check_eq("post_reset_ready0", 32'(req0_ready), 32'd1);
      check_eq("post_reset_ready1", 32'(req1_ready), 32'd0);
      at_posedge();
      drive0(0, 6'h24, 0, 0);
      drive1(0, 6'h25, 0, 0);
      repeat (3) cycle();

      // Randomized traffic, including dropped requests and occasional resets.
      repeat (400) begin
         logic [31:0] a0, b0;
         a0 = $urandom;
         b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
         drive0($urandom_range(0, 9) < 6, functs[$urandom_range(0, 4)], a0, b0);
         drive1($urandom_range(0, 9) < 6, functs[$urandom_range(0, 4)], $urandom, $urandom);
         force_err = ($urandom_range(0, 15) == 0);
         reset     = ($urandom_range(0, 49) != 0);
         cycle();
      end
      reset = 1'b1;
      force_err = 1'b0;
      drive0(0, 6'h20, 0, 0);
      drive1(0, 6'h20, 0, 0);
      repeat (3) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
